// File: rtl/ahb_pkg.sv
// Shared AHB encodings, the slave state type and the byte-lane helper used by
// the SRAM slave and its storage bank.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR1 = 2'b10,
    ERR2 = 2'b11
  } slave_state_t;

  // Little-endian lane enables; only called for legal (aligned) transfers.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-wide storage: synchronous byte-enabled write, asynchronous read so a
// word written on one edge is visible to the very next data phase.
module ahb_sram_bank #(
  parameter int WORDS = 1024,
  parameter int IW    = 10
) (
  input  logic          HCLK,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:WORDS-1];

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: address-phase capture, legality check, wait-state and
// two-cycle ERROR sequencing in front of an ahb_sram_bank.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter logic [1:0] SLAVE_ID    = 2'b11,
  parameter int         MEM_BYTES   = 4096,
  parameter int         WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WIDX  = (AW > 2) ? AW - 2 : 1;
  localparam int WORDS = MEM_BYTES / 4;

  slave_state_t  state_reg;
  logic          hready_reg;
  hresp_t        hresp_reg;
  logic [3:0]    wait_cnt_reg;
  logic [AW-1:0] addr_reg;
  logic          write_reg;
  logic [2:0]    size_reg;
  logic          pend_reg;

  logic          accept;
  logic          misaligned;
  logic          legal;
  logic          done;
  logic [31:0]   rdata;
  logic [WIDX-1:0] word_idx;
  logic          unused_bits;

  assign unused_bits = ^{HBURST, HTRANS[0]};

  assign accept     = (HSEL == SLAVE_ID) && HTRANS[1] && HREADY && hready_reg;
  assign misaligned = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign legal      = (HSIZE <= HSIZE_WORD) && (HADDR < 32'(MEM_BYTES)) && !misaligned;

  // A legal transfer completes in the first data-phase cycle with HREADYOUT high.
  assign done     = pend_reg && hready_reg;
  assign word_idx = WIDX'(addr_reg >> 2);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= IDLE;
      hready_reg   <= 1'b1;
      hresp_reg    <= HRESP_OKAY;
      wait_cnt_reg <= 4'd0;
      addr_reg     <= '0;
      write_reg    <= 1'b0;
      size_reg     <= 3'b000;
      pend_reg     <= 1'b0;
    end else begin
      case (state_reg)
        WAIT: begin
          wait_cnt_reg <= wait_cnt_reg - 4'd1;
          if (wait_cnt_reg == 4'd1) begin
            state_reg  <= IDLE;
            hready_reg <= 1'b1;
          end
        end
        ERR1: begin
          state_reg  <= ERR2;
          hready_reg <= 1'b1;
          hresp_reg  <= HRESP_ERROR;
        end
        default: begin
          // IDLE and ERR2 both end a data phase and may take a new address phase.
          state_reg  <= IDLE;
          hready_reg <= 1'b1;
          hresp_reg  <= HRESP_OKAY;
          pend_reg   <= accept && legal;
          if (accept) begin
            if (!legal) begin
              state_reg  <= ERR1;
              hready_reg <= 1'b0;
              hresp_reg  <= HRESP_ERROR;
            end else begin
              addr_reg  <= HADDR[AW-1:0];
              write_reg <= HWRITE;
              size_reg  <= HSIZE;
              if (WAIT_STATES > 0) begin
                state_reg    <= WAIT;
                hready_reg   <= 1'b0;
                wait_cnt_reg <= 4'(WAIT_STATES);
              end
            end
          end
        end
      endcase
    end
  end

  ahb_sram_bank #(
    .WORDS (WORDS),
    .IW    (WIDX)
  ) u_bank (
    .HCLK  (HCLK),
    .we    (done && write_reg),
    .be    (byte_en(size_reg, addr_reg[1:0])),
    .addr  (word_idx),
    .wdata (HWDATA),
    .rdata (rdata)
  );

  assign HREADYOUT = hready_reg;
  assign HRESP     = hresp_reg;
  assign HRDATA    = (done && !write_reg) ? rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: a zero-wait and a two-wait instance share
// the bus; a byte-level memory model schedules the per-cycle expected responses.
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;
  localparam logic [34:0] IDLE_RSP = {1'b1, 2'b00, 32'h0};

  logic        HCLK;
  logic        HRESETn;
  logic [1:0]  HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [1:0]  htrans0, htrans1;
  logic        hready0, hready1;
  logic [1:0]  hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;

  ahb_sram_slave #(.SLAVE_ID(2'b11), .MEM_BYTES(4096), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(htrans0),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hready0),
    .HREADYOUT(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
  );

  ahb_sram_slave #(.SLAVE_ID(2'b11), .MEM_BYTES(4096), .WAIT_STATES(2)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(htrans1),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hready1),
    .HREADYOUT(hready1), .HRESP(hresp1), .HRDATA(hrdata1)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int low1  = 0;

  always @(posedge HCLK) cyc <= cyc + 1;
  always @(negedge HCLK) if (!hready1) low1 <= low1 + 1;

  // Expected {HREADYOUT, HRESP, HRDATA} per DUT per cycle; unset cycles are idle OKAY.
  logic [34:0] exp_tab [2][2048];
  bit          exp_set [2][2048];
  logic [7:0]  mm      [2][4096];

  // Pending model write, committed once its completion cycle is reached.
  bit          p_valid;
  int          p_d, p_left;
  logic [31:0] p_addr, p_wdata;
  logic [2:0]  p_size;

  logic [34:0] e_v, a_v;

  always @(negedge HCLK) begin
    for (int d = 0; d < 2; d++) begin
      e_v = exp_set[d][cyc] ? exp_tab[d][cyc] : IDLE_RSP;
      a_v = (d == 0) ? {hready0, hresp0, hrdata0} : {hready1, hresp1, hrdata1};
      n_cmp++;
      if (a_v !== e_v) begin
        n_bad++;
        $display("FAIL model cyc=%0d dut%0d: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 cyc, d, a_v[34], a_v[33:32], a_v[31:0], e_v[34], e_v[33:32], e_v[31:0]);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic set_exp(input int d, input int c, input logic [34:0] v);
    exp_tab[d][c] = v;
    exp_set[d][c] = 1'b1;
  endtask

  function automatic logic [31:0] mread(input int d, input logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {mm[d][b+3], mm[d][b+2], mm[d][b+1], mm[d][b]};
  endfunction

  // Drive one address phase in the current cycle; return in the first data-phase cycle.
  task automatic addr_phase(input int d, input logic [1:0] sel, input logic [1:0] trans,
                            input logic wr, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
    int c, ws;
    bit acc, legal;
    c  = cyc;
    ws = (d == 0) ? 0 : 2;
    HSEL = sel; HADDR = addr; HWRITE = wr; HSIZE = size;
    htrans0 = (d == 0) ? trans : T_IDLE;
    htrans1 = (d == 1) ? trans : T_IDLE;
    acc   = (sel == 2'b11) && trans[1];
    legal = (size <= SZ_W) && (addr < 32'd4096) && ((int'(addr) % (1 << size)) == 0);
    p_valid = 1'b0;
    p_left  = 0;
    if (acc && !legal) begin
      set_exp(d, c + 1, {1'b0, 2'b01, 32'h0});
      set_exp(d, c + 2, {1'b1, 2'b01, 32'h0});
      p_left = 1;
    end else if (acc) begin
      for (int k = 1; k <= ws; k++) set_exp(d, c + k, {1'b0, 2'b00, 32'h0});
      set_exp(d, c + ws + 1, {1'b1, 2'b00, wr ? 32'h0 : mread(d, addr)});
      p_left = ws;
      p_valid = wr; p_d = d; p_addr = addr; p_size = size; p_wdata = wdata;
    end
    $display("xfer dut%0d sel=%b trans=%b %s size=%0d addr=%h wdata=%h", d, sel, trans,
             wr ? "WR" : "RD", size, addr, wdata);
    @(posedge HCLK); #1;
    htrans0 = T_IDLE; htrans1 = T_IDLE;
    HWDATA = wdata;
  endtask

  task automatic finish_xfer();
    int a;
    repeat (p_left) begin @(posedge HCLK); #1; end
    if (p_valid) begin
      for (int i = 0; i < (1 << p_size); i++) begin
        a = int'(p_addr) + i;
        mm[p_d][a] = p_wdata[8*(a & 3) +: 8];
      end
    end
    p_valid = 1'b0;
  endtask

  task automatic xfer(input int d, input logic [1:0] sel, input logic [1:0] trans,
                      input logic wr, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata);
    addr_phase(d, sel, trans, wr, size, addr, wdata);
    finish_xfer();
  endtask

  task automatic idle(input int n);
    htrans0 = T_IDLE; htrans1 = T_IDLE;
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  int low_before;

  initial begin
    HRESETn = 1'b0; HSEL = 2'b00; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = SZ_W;
    HBURST = 3'b000; HWDATA = 32'h0; htrans0 = T_IDLE; htrans1 = T_IDLE; p_valid = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    check("reset_rdy0",   {31'h0, hready0}, 32'h1);
    check("reset_resp1",  {30'h0, hresp1},  32'h0);
    check("reset_rdata1", hrdata1,          32'h0);
    HRESETn = 1'b1;
    idle(1);

    // Zero-wait write then read-back.
    xfer(0, 2'b11, T_NSEQ, 1'b1, SZ_W, 32'h000, 32'hDEADBEEF);
    xfer(0, 2'b11, T_NSEQ, 1'b0, SZ_W, 32'h000, 32'h0);
    check("t1_rdata", hrdata0, 32'hDEADBEEF);

    // Byte and halfword lanes.
    xfer(0, 2'b11, T_NSEQ, 1'b1, SZ_W, 32'h008, 32'h00000000);
    xfer(0, 2'b11, T_NSEQ, 1'b1, SZ_B, 32'h009, 32'h0000AB00);
    xfer(0, 2'b11, T_NSEQ, 1'b0, SZ_W, 32'h008, 32'h0);
    check("t3_byte", hrdata0, 32'h0000AB00);
    xfer(0, 2'b11, T_SEQ,  1'b1, SZ_H, 32'h00A, 32'hCDEF1234);
    xfer(0, 2'b11, T_SEQ,  1'b0, SZ_B, 32'h008, 32'h0);
    check("t3_half", hrdata0, 32'hCDEFAB00);

    // Illegal accesses, back-to-back from ERR2.
    xfer(0, 2'b11, T_NSEQ, 1'b1, SZ_W, 32'h002, 32'h11111111);
    check("t4_err2", {29'h0, hready0, hresp0}, 32'h5);
    xfer(0, 2'b11, T_NSEQ, 1'b1, SZ_W, 32'h1000, 32'h22222222);
    xfer(0, 2'b11, T_NSEQ, 1'b1, SZ_H, 32'h001, 32'h33333333);
    xfer(0, 2'b11, T_NSEQ, 1'b1, 3'b011, 32'h000, 32'h44444444);
    xfer(0, 2'b11, T_NSEQ, 1'b0, SZ_W, 32'h000, 32'h0);
    check("t4_mem_kept", hrdata0, 32'hDEADBEEF);

    // Unselected and BUSY transfers have no effect.
    idle(1);
    xfer(0, 2'b01, T_NSEQ, 1'b1, SZ_W, 32'h000, 32'h55555555);
    xfer(0, 2'b11, T_BUSY, 1'b1, SZ_W, 32'h000, 32'h66666666);
    xfer(0, 2'b11, T_NSEQ, 1'b0, SZ_W, 32'h000, 32'h0);
    check("t5_no_write", hrdata0, 32'hDEADBEEF);
    idle(2);

    // Two wait states.
    xfer(1, 2'b11, T_NSEQ, 1'b1, SZ_W, 32'h004, 32'h12345678);
    low_before = low1;
    xfer(1, 2'b11, T_NSEQ, 1'b0, SZ_W, 32'h004, 32'h0);
    check("t2_waits", 32'(low1 - low_before), 32'd2);
    check("t2_rdata", hrdata1, 32'h12345678);
    idle(1);

    // Reset in the middle of the second of two back-to-back writes.
    xfer(1, 2'b11, T_NSEQ, 1'b1, SZ_W, 32'h014, 32'hA5A5A5A5);
    xfer(1, 2'b11, T_NSEQ, 1'b1, SZ_W, 32'h010, 32'hCAFEF00D);
    addr_phase(1, 2'b11, T_SEQ, 1'b1, SZ_W, 32'h014, 32'h0BADBEEF);
    check("t6_in_wait", {31'h0, hready1}, 32'h0);
    #1;
    for (int k = cyc; k < 2048; k++) begin exp_set[0][k] = 1'b0; exp_set[1][k] = 1'b0; end
    p_valid = 1'b0;
    HRESETn = 1'b0;
    #1;
    check("t6_rst_rdy",   {31'h0, hready1}, 32'h1);
    check("t6_rst_resp",  {30'h0, hresp1},  32'h0);
    check("t6_rst_rdata", hrdata1,          32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    idle(1);
    xfer(1, 2'b11, T_NSEQ, 1'b0, SZ_W, 32'h010, 32'h0);
    check("t6_kept_010", hrdata1, 32'hCAFEF00D);
    xfer(1, 2'b11, T_NSEQ, 1'b0, SZ_W, 32'h014, 32'h0);
    check("t6_kept_014", hrdata1, 32'hA5A5A5A5);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
